// File: rtl/reg_bank_pkg.sv
// Shared constants for reg_bank: FSM state encodings and command-priority codes.
// Pure definitions, no logic, no latency, no backpressure.
// Imported by reg_bank (optional flags feature: REG_BANK_FLAGS_EN).
package reg_bank_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XCH1 = 2'd1;
    localparam logic [1:0] ST_XCH2 = 2'd2;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_XCHG = 3'd1;
    localparam logic [2:0] CMD_LOAD = 3'd2;
    localparam logic [2:0] CMD_INC  = 3'd3;
    localparam logic [2:0] CMD_DEC  = 3'd4;

    // Winner of the request lines, highest priority first.
    function automatic logic [2:0] cmd_pick(input logic xchg, input logic load,
                                            input logic inc, input logic dec);
        if (xchg)      return CMD_XCHG;
        else if (load) return CMD_LOAD;
        else if (inc)  return CMD_INC;
        else if (dec)  return CMD_DEC;
        else           return CMD_NONE;
    endfunction

    function automatic logic cmd_multi(input logic xchg, input logic load,
                                       input logic inc, input logic dec);
        return $countones({xchg, load, inc, dec}) > 1;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Command/bus bundle between the SAP-2 controller (master) and reg_bank (slave).
// Wires only: zero latency, no backpressure beyond the busy indication.
// Flag outputs are meaningful only when REG_BANK_FLAGS_EN is defined.
interface reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]    sel;
    logic [AW-1:0]    sel2;
    logic             load;
    logic             inc;
    logic             dec;
    logic             xchg;
    logic             en;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             busy;
    logic             err;
    logic             flag_z;
    logic             flag_s;
    logic             flag_c;

    modport master (
        output sel, sel2, load, inc, dec, xchg, en, bus_in,
        input  bus_out, busy, err, flag_z, flag_s, flag_c
    );

    modport slave (
        input  sel, sel2, load, inc, dec, xchg, en, bus_in,
        output bus_out, busy, err, flag_z, flag_s, flag_c
    );
endinterface

// File: rtl/reg_bank_flags.sv
// Zero/sign/carry status registers fed from the bank's single write port.
// Latency: flags valid the cycle after the write; never stalls.
// Built only when REG_BANK_FLAGS_EN is defined.
module reg_bank_flags #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [WIDTH-1:0] val,
    input  logic             c_upd,
    input  logic             c_in,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_s <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (upd) begin
                flag_z <= (val == '0);
                flag_s <= val[WIDTH-1];
            end
            // Carry only moves on inc/dec; load and exchange leave it alone.
            if (c_upd)
                flag_c <= c_in;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// NREGS x WIDTH register bank: load/inc/dec in 1 cycle, two-cycle exchange, bus drive.
// Latency: results next cycle; xchg holds busy for 2 cycles, commands while busy are dropped and flag err.
// Status flags exist only when REG_BANK_FLAGS_EN is defined; otherwise flag outputs are tied 0.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] tmp;
    logic [AW-1:0]    xa;
    logic [AW-1:0]    xb;
    logic [1:0]       state;
    logic             err_q;

    logic [2:0]       cmd;
    logic             multi;
    logic             any_cmd;
    logic [WIDTH-1:0] cur;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_val;
    logic             flag_upd;
    logic             c_upd;
    logic             c_val;

    assign cmd     = cmd_pick(bus.xchg, bus.load, bus.inc, bus.dec);
    assign multi   = cmd_multi(bus.xchg, bus.load, bus.inc, bus.dec);
    assign any_cmd = bus.xchg | bus.load | bus.inc | bus.dec;
    assign cur     = regs[bus.sel];

    // Single write port: every register update in the bank goes through here.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = bus.sel;
        wr_val   = bus.bus_in;
        flag_upd = 1'b0;
        c_upd    = 1'b0;
        c_val    = 1'b0;
        case (state)
            ST_IDLE: begin
                case (cmd)
                    CMD_LOAD: begin
                        wr_en    = 1'b1;
                        flag_upd = 1'b1;
                    end
                    CMD_INC: begin
                        wr_en    = 1'b1;
                        wr_val   = cur + ONE;
                        flag_upd = 1'b1;
                        c_upd    = 1'b1;
                        c_val    = &cur;
                    end
                    CMD_DEC: begin
                        wr_en    = 1'b1;
                        wr_val   = cur - ONE;
                        flag_upd = 1'b1;
                        c_upd    = 1'b1;
                        c_val    = (cur == '0);
                    end
                    default: ;
                endcase
            end
            ST_XCH1: begin
                wr_en  = 1'b1;
                wr_idx = xb;
                wr_val = regs[xa];
            end
            ST_XCH2: begin
                wr_en    = 1'b1;
                wr_idx   = xa;
                wr_val   = tmp;
                flag_upd = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            tmp   <= '0;
            xa    <= '0;
            xb    <= '0;
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            if (wr_en)
                regs[wr_idx] <= wr_val;
            case (state)
                ST_IDLE: begin
                    if (multi)
                        err_q <= 1'b1;
                    if (cmd == CMD_XCHG) begin
                        xa    <= bus.sel;
                        xb    <= bus.sel2;
                        state <= ST_XCH1;
                    end
                end
                ST_XCH1: begin
                    tmp   <= regs[xb];
                    state <= ST_XCH2;
                    if (any_cmd)
                        err_q <= 1'b1;
                end
                ST_XCH2: begin
                    state <= ST_IDLE;
                    if (any_cmd)
                        err_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bus_out = bus.en ? cur : '0;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.err     = err_q;

`ifdef REG_BANK_FLAGS_EN
    reg_bank_flags #(.WIDTH(WIDTH)) u_flags (
        .clk    (clk),
        .rst    (rst),
        .upd    (flag_upd),
        .val    (wr_val),
        .c_upd  (c_upd),
        .c_in   (c_val),
        .flag_z (bus.flag_z),
        .flag_s (bus.flag_s),
        .flag_c (bus.flag_c)
    );
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = flag_upd ^ c_upd ^ c_val;
    assign bus.flag_z = 1'b0;
    assign bus.flag_s = 1'b0;
    assign bus.flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: reset, load/inc/dec, exchange, error stickiness.
// Expected flag values follow REG_BANK_FLAGS_EN (all zero when the feature is off).
module tb_reg_bank;

`ifdef REG_BANK_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [7:0] v;

    reg_bank_if #(.WIDTH(8), .NREGS(4)) bif ();

    reg_bank #(.WIDTH(8), .NREGS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.sel = '0; bif.sel2 = '0; bif.load = 0; bif.inc = 0; bif.dec = 0;
        bif.xchg = 0; bif.en = 0; bif.bus_in = '0;
    endtask

    task automatic do_load(input int idx, input logic [7:0] val);
        bif.sel = 2'(idx); bif.bus_in = val; bif.load = 1;
        tick();
        bif.load = 0;
    endtask

    task automatic do_inc(input int idx);
        bif.sel = 2'(idx); bif.inc = 1;
        tick();
        bif.inc = 0;
    endtask

    task automatic do_dec(input int idx);
        bif.sel = 2'(idx); bif.dec = 1;
        tick();
        bif.dec = 0;
    endtask

    // Combinational read within the current cycle; no command is active.
    task automatic rd(input int idx, output logic [7:0] val);
        bif.sel = 2'(idx); bif.en = 1;
        #1;
        val = bif.bus_out;
        bif.en = 0;
        #1;
    endtask

    initial begin
        idle_inputs();
        tick();
        tick();
        rst = 0;
        tick();

        // Reset state
        rd(0, v);  check("reset_r0", v, 8'h00);
        rd(3, v);  check("reset_r3", v, 8'h00);
        check("reset_busy", bif.busy, 1'b0);
        check("reset_err", bif.err, 1'b0);
        check("reset_z", bif.flag_z, 1'b0);
        check("reset_c", bif.flag_c, 1'b0);

        // Reset during XCH1 abandons the swap
        do_load(0, 8'h12);
        do_load(1, 8'h34);
        bif.sel = 0; bif.sel2 = 1; bif.xchg = 1;
        tick();
        bif.xchg = 0;
        check("midx_busy_before_rst", bif.busy, 1'b1);
        rst = 1;
        #1;
        check("midx_busy_async", bif.busy, 1'b0);
        tick();
        rst = 0;
        tick();
        rd(0, v);  check("midx_r0", v, 8'h00);
        rd(1, v);  check("midx_r1", v, 8'h00);
        check("midx_busy", bif.busy, 1'b0);
        check("midx_err", bif.err, 1'b0);

        // Load and readback
        do_load(2, 8'hA5);
        rd(2, v);  check("load_r2", v, 8'hA5);
        check("load_s", bif.flag_s, FL);
        check("load_z", bif.flag_z, 1'b0);
        bif.sel = 2; bif.en = 0; #1;
        check("en_low_bus", bif.bus_out, 8'h00);

        // Increment wrap and following inc
        do_load(1, 8'hFF);
        do_inc(1);
        rd(1, v);  check("inc_wrap_r1", v, 8'h00);
        check("inc_wrap_z", bif.flag_z, FL);
        check("inc_wrap_c", bif.flag_c, FL);
        do_inc(1);
        rd(1, v);  check("inc_r1", v, 8'h01);
        check("inc_c", bif.flag_c, 1'b0);
        check("inc_z", bif.flag_z, 1'b0);

        // Decrement borrow
        do_load(3, 8'h00);
        do_dec(3);
        rd(3, v);  check("dec_r3", v, 8'hFF);
        check("dec_c", bif.flag_c, FL);
        check("dec_s", bif.flag_s, FL);

        // Exchange with a load injected while busy
        do_load(0, 8'h12);
        do_load(1, 8'h34);
        check("xchg_c_held_by_load", bif.flag_c, FL);
        bif.sel = 0; bif.sel2 = 1; bif.xchg = 1;
        tick();
        bif.xchg = 0;
        check("xchg_busy1", bif.busy, 1'b1);
        bif.sel = 2; bif.bus_in = 8'h77; bif.load = 1;
        tick();
        bif.load = 0;
        check("xchg_busy2", bif.busy, 1'b1);
        check("xchg_err", bif.err, 1'b1);
        tick();
        check("xchg_busy_fall", bif.busy, 1'b0);
        rd(0, v);  check("xchg_r0", v, 8'h34);
        rd(1, v);  check("xchg_r1", v, 8'h12);
        rd(2, v);  check("xchg_load_ignored", v, 8'hA5);
        check("xchg_z", bif.flag_z, 1'b0);
        check("xchg_s", bif.flag_s, 1'b0);
        check("xchg_c_held", bif.flag_c, FL);

        // Self-exchange leaves the value unchanged
        bif.sel = 2; bif.sel2 = 2; bif.xchg = 1;
        tick();
        bif.xchg = 0;
        tick();
        check("self_busy2", bif.busy, 1'b1);
        tick();
        check("self_busy_fall", bif.busy, 1'b0);
        rd(2, v);  check("self_r2", v, 8'hA5);
        check("self_s", bif.flag_s, FL);

        // Simultaneous commands: load wins, err sticky until reset
        rst = 1;
        tick();
        rst = 0;
        tick();
        check("pre_multi_err", bif.err, 1'b0);
        bif.sel = 0; bif.bus_in = 8'h40; bif.load = 1; bif.inc = 1;
        tick();
        bif.load = 0; bif.inc = 0;
        rd(0, v);  check("multi_r0", v, 8'h40);
        check("multi_err", bif.err, 1'b1);
        do_load(1, 8'h05);
        rd(1, v);  check("post_load_r1", v, 8'h05);
        check("err_sticky", bif.err, 1'b1);
        rst = 1;
        tick();
        rst = 0;
        check("err_cleared", bif.err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
